// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Active-low snapshot with no key down.
  localparam logic [KEYS-1:0] KEY_RELEASED_ALL = 16'hFFFF;

  // Bit position of a key inside the active-low snapshot.
  function automatic int unsigned key_index(input int unsigned row, input int unsigned col);
    return row * COLS + col;
  endfunction

  // Active-low row drive pattern selecting exactly one row.
  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] row);
    return ~(ROWS'(1) << row);
  endfunction

  // Number of keys held (zero bits) in an active-low snapshot.
  function automatic logic [4:0] count_pressed(input logic [KEYS-1:0] keys_n);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (!keys_n[i]) n = n + 5'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser; resets to all-ones so
// pulled-up lines read as idle until real samples arrive.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-at-a-time scanner for a 4x4 matrix keypad. Builds an active-low
// 16-key snapshot and publishes it once per complete frame together with
// a one-cycle frame strobe and a multi-key flag.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC = 999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scan_en,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key_state,
  output logic        frame_done,
  output logic        multi_key
);

  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYC);

  scan_state_e      state_q;
  logic [1:0]       row_idx_q;
  logic [19:0]      cnt_q;
  logic [KEYS-1:0]  shadow_q;
  logic [ROWS-1:0]  row_out_q;
  logic [KEYS-1:0]  key_state_q;
  logic             frame_done_q;
  logic             multi_key_q;

  logic [COLS-1:0]  col_sync;
  logic [KEYS-1:0]  shadow_merged;
  logic             sample_edge;
  logic             last_row;

  sync2 #(
    .WIDTH(COLS)
  ) u_col_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (col_in),
    .q_o  (col_sync)
  );

  assign sample_edge = (state_q == ST_SCAN) && (cnt_q == SETTLE_LAST);
  assign last_row    = (row_idx_q == 2'(ROWS - 1));

  // Shadow with the current row's nibble replaced by the synchronised columns.
  always_comb begin
    shadow_merged = shadow_q;
    shadow_merged[key_index(32'(row_idx_q), 0) +: COLS] = col_sync;
  end

  // Scan FSM: row sequencing, dwell counting, snapshot assembly and publishing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      row_idx_q    <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= KEY_RELEASED_ALL;
      row_out_q    <= '1;
      key_state_q  <= KEY_RELEASED_ALL;
      frame_done_q <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          row_out_q <= '1;
          if (scan_en) begin
            state_q   <= ST_SCAN;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            row_out_q <= row_drive(2'd0);
          end
        end
        ST_SCAN: begin
          if (!scan_en && !(sample_edge && last_row)) begin
            // Abort: a partially assembled frame is never published.
            state_q   <= ST_IDLE;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= KEY_RELEASED_ALL;
            row_out_q <= '1;
          end else if (sample_edge) begin
            shadow_q  <= shadow_merged;
            cnt_q     <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_out_q <= row_drive(row_idx_q + 2'd1);
            if (last_row) begin
              key_state_q  <= shadow_merged;
              frame_done_q <= 1'b1;
              multi_key_q  <= (count_pressed(shadow_merged) > 5'd1);
              shadow_q     <= KEY_RELEASED_ALL;
              if (!scan_en) begin
                // Frame completed on the way out; stop with rows released.
                state_q   <= ST_IDLE;
                row_out_q <= '1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          row_out_q <= '1;
        end
      endcase
    end
  end

  assign row_out    = row_out_q;
  assign key_state  = key_state_q;
  assign frame_done = frame_done_q;
  assign multi_key  = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with a behavioural keypad matrix.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 7;
  localparam int ROW_CYC = SETTLE + 1;
  localparam int FRAME_CYC = 4 * ROW_CYC;
  localparam int FRAME_TIMEOUT = 200;

  logic        clk;
  logic        rstn;
  logic        scan_en;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_state;
  logic        frame_done;
  logic        multi_key;

  logic        force_en;
  logic [3:0]  force_val;
  logic [15:0] pressed;   // 1 = key held, bit = row*4+col

  int checks;
  int errors;

  logic [15:0] prev_ks;
  logic        prev_valid;

  keypad_scan_ctrl #(
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .scan_en    (scan_en),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_state  (key_state),
    .frame_done (frame_done),
    .multi_key  (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a column reads low when a held key sits on a driven row.
  function automatic logic [3:0] keypad(input logic [3:0] rows, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (!rows[r] && p[r*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign col_in = force_en ? force_val : keypad(row_out, pressed);

  // Reference: a stable frame reports every held key as a zero bit.
  function automatic logic [15:0] model_ks(input logic [15:0] mask);
    return ~mask;
  endfunction

  function automatic logic model_multi(input logic [15:0] mask);
    return $countones(mask) > 1;
  endfunction

  // Continuous invariants: key_state moves only with frame_done, one row at most.
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if (prev_valid && key_state !== prev_ks && frame_done !== 1'b1) begin
        errors++;
        $display("FAIL key_state_stable actual=%h required=%h (no frame_done)", key_state, prev_ks);
      end
      checks++;
      if ($countones(~row_out) > 1) begin
        errors++;
        $display("FAIL row_onehot actual=%b required=at most one low bit", row_out);
      end
    end
    prev_ks    = key_state;
    prev_valid = rstn;
  end

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < FRAME_TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame actual=no_frame_done required=frame_done_within_%0d", FRAME_TIMEOUT);
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] mask);
    checks++;
    if (key_state !== model_ks(mask)) begin
      errors++;
      $display("FAIL %s key_state actual=%h required=%h", name, key_state, model_ks(mask));
    end
    checks++;
    if (multi_key !== model_multi(mask)) begin
      errors++;
      $display("FAIL %s multi_key actual=%b required=%b", name, multi_key, model_multi(mask));
    end
    $display("frame %s mask=%h key_state=%h multi_key=%b", name, mask, key_state, multi_key);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    scan_en = 1'b0;
    force_en = 1'b1;
    force_val = 4'h0;
    pressed = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (row_out !== 4'hF || key_state !== 16'hFFFF || frame_done !== 1'b0 || multi_key !== 1'b0) begin
        errors++;
        $display("FAIL reset_values actual=%b/%h/%b/%b required=1111/ffff/0/0",
                 row_out, key_state, frame_done, multi_key);
      end
    end
    rstn = 1'b1;
    force_en = 1'b0;
    @(negedge clk);
    checks++;
    if (row_out !== 4'hF) begin
      errors++;
      $display("FAIL idle_row_out actual=%b required=1111", row_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan_timing();
    logic [3:0] exp_row;
    logic       exp_fd;
    scan_en = 1'b1;
    for (int n = 0; n < 3 * FRAME_CYC; n++) begin
      @(negedge clk);
      exp_row = ~(4'(1) << ((n / ROW_CYC) % 4));
      exp_fd  = (n > 0) && (n % FRAME_CYC == 0);
      checks++;
      if (row_out !== exp_row) begin
        errors++;
        $display("FAIL scan_row n=%0d actual=%b required=%b", n, row_out, exp_row);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL scan_frame_done n=%0d actual=%b required=%b", n, frame_done, exp_fd);
      end
    end
    check_frame("no_keys", 16'h0000);
  endtask

  task automatic test_single_key();
    pressed = 16'h0200;   // row2/col1
    wait_frame();
    wait_frame();
    check_frame("row2_col1", pressed);
  endtask

  task automatic test_two_keys();
    pressed = 16'h8001;   // row0/col0 and row3/col3
    wait_frame();
    wait_frame();
    check_frame("corners", pressed);
    pressed = 16'h0000;
    wait_frame();
    wait_frame();
    check_frame("release", pressed);
  endtask

  task automatic test_disable_mid_frame();
    logic [15:0] held;
    logic [3:0]  exp_row;
    logic        exp_fd;
    pressed = 16'h0048;
    wait_frame();
    wait_frame();
    check_frame("pre_disable", pressed);
    held = pressed;
    wait_frame();
    repeat (2 * ROW_CYC + 4) @(negedge clk);
    checks++;
    if (row_out !== 4'b1011) begin
      errors++;
      $display("FAIL disable_align actual=%b required=1011", row_out);
    end
    scan_en = 1'b0;
    pressed = 16'h1000;   // changes while idle must not show up
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      checks++;
      if (row_out !== 4'hF || frame_done !== 1'b0 || key_state !== model_ks(held) ||
          multi_key !== model_multi(held)) begin
        errors++;
        $display("FAIL disable_hold n=%0d actual=%b/%b/%h/%b required=1111/0/%h/%b",
                 n, row_out, frame_done, key_state, multi_key, model_ks(held), model_multi(held));
      end
    end
    scan_en = 1'b1;
    for (int n = 0; n <= FRAME_CYC; n++) begin
      @(negedge clk);
      exp_row = ~(4'(1) << ((n / ROW_CYC) % 4));
      exp_fd  = (n == FRAME_CYC);
      checks++;
      if (row_out !== exp_row) begin
        errors++;
        $display("FAIL restart_row n=%0d actual=%b required=%b", n, row_out, exp_row);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL restart_frame_done n=%0d actual=%b required=%b", n, frame_done, exp_fd);
      end
    end
    check_frame("restart", pressed);
  endtask

  task automatic test_reset_mid_frame();
    pressed = 16'h0020;   // row1/col1
    wait_frame();
    repeat (ROW_CYC + 2) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (row_out !== 4'hF || key_state !== 16'hFFFF || frame_done !== 1'b0 || multi_key !== 1'b0) begin
      errors++;
      $display("FAIL async_reset actual=%b/%h/%b/%b required=1111/ffff/0/0",
               row_out, key_state, frame_done, multi_key);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (key_state !== 16'hFFFF) begin
      errors++;
      $display("FAIL post_reset_ks actual=%h required=ffff", key_state);
    end
    wait_frame();
    check_frame("after_reset", pressed);
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int k;
    for (int it = 0; it < 10; it++) begin
      mask = '0;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) mask[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      pressed = mask;
      wait_frame();
      wait_frame();
      check_frame($sformatf("rand%0d", it), mask);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_valid = 1'b0;
    prev_ks = '1;
    test_reset();
    test_scan_timing();
    test_single_key();
    test_two_keys();
    test_disable_mid_frame();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
